// File: rtl/mux_nto1_stream.sv
// Registered N-to-1 stream multiplexer with fixed-select or round-robin arbitration.
// Optional accepted-output counter (xfer_cnt_o) is built when MUX_STATS_EN is defined.
module mux_nto1_stream #(
  parameter int N = 2,
  parameter int WIDTH = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] d_i,
  input  logic [N-1:0]       valid_i,
  output logic [N-1:0]       ready_o,
  input  logic [SELW-1:0]    sel_i,
  input  logic               rr_mode_i,
  output logic [WIDTH-1:0]   y_o,
  output logic               y_valid_o,
  input  logic               y_ready_i,
  output logic [SELW-1:0]    y_src_o
`ifdef MUX_STATS_EN
  ,
  output logic [15:0]        xfer_cnt_o
`endif
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  cand;
  logic [SELW-1:0]  grant_idx;
  logic             grant;
  logic             ld;
  logic [WIDTH-1:0] grant_data;

  assign ld = !y_valid_o || y_ready_i;

  // Round-robin searches ptr+1, ptr+2, ... so the last winner gets lowest priority.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (N == 1) begin
      grant = valid_i[0];
    end else if (rr_mode_i) begin
      for (int i = 1; i <= N; i++) begin
        cand = SELW'((int'(ptr) + i) % N);
        if (!grant && valid_i[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end else if (int'(sel_i) < N) begin
      grant     = valid_i[sel_i];
      grant_idx = sel_i;
    end
  end

  always_comb begin
    grant_data = d_i[grant_idx*WIDTH +: WIDTH];
    ready_o    = '0;
    if (rst_n && ld && grant) begin
      ready_o[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_o       <= '0;
      y_valid_o <= 1'b0;
      y_src_o   <= '0;
      ptr       <= SELW'(N - 1);
    end else if (ld) begin
      if (grant) begin
        y_o       <= grant_data;
        y_src_o   <= grant_idx;
        y_valid_o <= 1'b1;
        ptr       <= grant_idx;
      end else begin
        y_valid_o <= 1'b0;
      end
    end
  end

`ifdef MUX_STATS_EN
  // Saturating count of outputs the consumer actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_o <= 16'd0;
    end else if (y_valid_o && y_ready_i && xfer_cnt_o != 16'hFFFF) begin
      xfer_cnt_o <= xfer_cnt_o + 16'd1;
    end
  end
`else
  // No transfer counter in this build.
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed self-checking bench for mux_nto1_stream using N=2, N=3 and N=4 instances.
// Counter checks run only when MUX_STATS_EN is defined.
module tb_mux_nto1_stream;

  logic clk;
  logic rst_n;

  int compared;
  int mismatched;

  // N=4 instance
  logic [15:0] d4;
  logic [3:0]  valid4;
  logic [3:0]  ready4;
  logic [1:0]  sel4;
  logic        rr4;
  logic [3:0]  y4;
  logic        yv4;
  logic        yr4;
  logic [1:0]  src4;

  // N=2 instance
  logic [7:0]  d2;
  logic [1:0]  valid2;
  logic [1:0]  ready2;
  logic        sel2;
  logic        rr2;
  logic [3:0]  y2;
  logic        yv2;
  logic        yr2;
  logic        src2;

  // N=3 instance
  logic [11:0] d3;
  logic [2:0]  valid3;
  logic [2:0]  ready3;
  logic [1:0]  sel3;
  logic        rr3;
  logic [3:0]  y3;
  logic        yv3;
  logic        yr3;
  logic [1:0]  src3;

`ifdef MUX_STATS_EN
  logic [15:0] cnt4;
  logic [15:0] cnt2;
  logic [15:0] cnt3;
`endif

  mux_nto1_stream #(.N(4), .WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .d_i(d4), .valid_i(valid4), .ready_o(ready4),
    .sel_i(sel4), .rr_mode_i(rr4), .y_o(y4), .y_valid_o(yv4),
    .y_ready_i(yr4), .y_src_o(src4)
`ifdef MUX_STATS_EN
    , .xfer_cnt_o(cnt4)
`endif
  );

  mux_nto1_stream #(.N(2), .WIDTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .d_i(d2), .valid_i(valid2), .ready_o(ready2),
    .sel_i(sel2), .rr_mode_i(rr2), .y_o(y2), .y_valid_o(yv2),
    .y_ready_i(yr2), .y_src_o(src2)
`ifdef MUX_STATS_EN
    , .xfer_cnt_o(cnt2)
`endif
  );

  mux_nto1_stream #(.N(3), .WIDTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .d_i(d3), .valid_i(valid3), .ready_o(ready3),
    .sel_i(sel3), .rr_mode_i(rr3), .y_o(y3), .y_valid_o(yv3),
    .y_ready_i(yr3), .y_src_o(src3)
`ifdef MUX_STATS_EN
    , .xfer_cnt_o(cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held with every input active.
    rst_n  = 1'b0;
    d4 = 16'hDCBA; valid4 = 4'hF; sel4 = 2'd1; rr4 = 1'b1; yr4 = 1'b1;
    d2 = 8'hA5;    valid2 = 2'b11; sel2 = 1'b1; rr2 = 1'b0; yr2 = 1'b1;
    d3 = 12'h321;  valid3 = 3'b111; sel3 = 2'd3; rr3 = 1'b0; yr3 = 1'b1;
    tick();
    tick();
    check_output("rst_y_valid", 32'(yv4), 32'd0);
    check_output("rst_y", 32'(y4), 32'd0);
    check_output("rst_ready", 32'(ready4), 32'd0);
    check_output("rst_src", 32'(src4), 32'd0);
    check_output("rst_ready_n2", 32'(ready2), 32'd0);

    // Park N=4 and N=3 while N=2 runs fixed-select checks.
    valid4 = 4'h0;
    valid3 = 3'b000;
    rst_n  = 1'b1;
    #1;
    check_output("fix_ready_sel1", 32'(ready2), 32'h2);
    tick();
    check_output("fix_y_sel1", 32'(y2), 32'hA);
    check_output("fix_src_sel1", 32'(src2), 32'd1);
    check_output("fix_yv_sel1", 32'(yv2), 32'd1);
    sel2 = 1'b0;
    #1;
    check_output("fix_ready_sel0", 32'(ready2), 32'h1);
    tick();
    check_output("fix_y_sel0", 32'(y2), 32'h5);
    check_output("fix_src_sel0", 32'(src2), 32'd0);
    sel2 = 1'b1;
    valid2 = 2'b01;
    #1;
    check_output("fix_ready_novalid", 32'(ready2), 32'h0);
    tick();
    check_output("fix_yv_nogrant", 32'(yv2), 32'd0);
    check_output("fix_y_hold", 32'(y2), 32'h5);
    valid2 = 2'b00;

    // N=3: select index 3 is out of range and must never grant.
    valid3 = 3'b111;
    #1;
    check_output("n3_sel3_ready", 32'(ready3), 32'h0);
    tick();
    check_output("n3_sel3_yv_a", 32'(yv3), 32'd0);
    tick();
    check_output("n3_sel3_yv_b", 32'(yv3), 32'd0);
    sel3 = 2'd2;
    #1;
    check_output("n3_sel2_ready", 32'(ready3), 32'h4);
    tick();
    check_output("n3_sel2_y", 32'(y3), 32'h3);
    check_output("n3_sel2_src", 32'(src3), 32'd2);
    valid3 = 3'b000;

    // N=4 round-robin, all channels valid: grants 0,1,2,3,0.
    rr4 = 1'b1;
    valid4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output($sformatf("rr_ready_%0d", i), 32'(ready4), 32'(1 << (i % 4)));
      tick();
      check_output($sformatf("rr_src_%0d", i), 32'(src4), 32'(i % 4));
      check_output($sformatf("rr_y_%0d", i), 32'(y4), 32'(4'hA + (i % 4)));
    end

    // Backpressure: held output, no ready to any channel.
    yr4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output($sformatf("bp_ready_%0d", i), 32'(ready4), 32'h0);
      tick();
      check_output($sformatf("bp_y_%0d", i), 32'(y4), 32'hA);
      check_output($sformatf("bp_yv_%0d", i), 32'(yv4), 32'd1);
    end
    yr4 = 1'b1;
    #1;
    check_output("bp_release_ready", 32'(ready4), 32'h2);
    tick();
    check_output("bp_release_y", 32'(y4), 32'hB);
    check_output("bp_release_src", 32'(src4), 32'd1);

    // Move pointer to 2, then only channel 2 valid must wrap back to 2.
    valid4 = 4'b0100;
    #1;
    check_output("wrap_pre_ready", 32'(ready4), 32'h4);
    tick();
    check_output("wrap_pre_src", 32'(src4), 32'd2);
    #1;
    check_output("wrap_ready", 32'(ready4), 32'h4);
    tick();
    check_output("wrap_src", 32'(src4), 32'd2);
    check_output("wrap_y", 32'(y4), 32'hC);

    // Fixed grant of 3 moves the pointer; round-robin then resumes at 0.
    rr4 = 1'b0;
    sel4 = 2'd3;
    valid4 = 4'hF;
    #1;
    check_output("mode_fix_ready", 32'(ready4), 32'h8);
    tick();
    check_output("mode_fix_y", 32'(y4), 32'hD);
    rr4 = 1'b1;
    #1;
    check_output("mode_rr_ready", 32'(ready4), 32'h1);
    tick();
    check_output("mode_rr_src", 32'(src4), 32'd0);

    // Reset asserted while output is valid drops it immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_yv", 32'(yv4), 32'd0);
    check_output("midrst_ready", 32'(ready4), 32'h0);

`ifdef MUX_STATS_EN
    check_output("cnt_reset", 32'(cnt4), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check_output("cnt_10", 32'(cnt4), 32'd10);
    for (int i = 0; i < 65537; i++) tick();
    check_output("cnt_sat", 32'(cnt4), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
